tiger_round: RTL and testbench
==============================

TIGER_ROUND -- requirements
Module: tiger_round

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_start  input  1  request one round; sampled only in IDLE.
REQ-005 i_a, i_b, i_c  input  64 each  round chaining words a, b, c.
REQ-006 i_x  input  64  message word x for this round.
REQ-007 i_mul  input  2  multiplier select: 0 = x5, 1 = x7, 2 = x9, 3 = reserved (behaves as x9).
REQ-008 o_a, o_b, o_c  output  64 each  round results.
REQ-009 o_valid  output  1  one-cycle pulse: o_a, o_b and o_c hold new results.
REQ-010 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 The block SHALL compute one Tiger round: c' = c ^ x; a' = a - (T1[c'0] ^ T2[c'2] ^ T3[c'4] ^ T4[c'6]); b' = (b + (T4[c'1] ^ T3[c'3] ^ T2[c'5] ^ T1[c'7])) * mul. Here c'n is byte n of c', with byte 0 = bits 7:0.
REQ-012 All arithmetic SHALL be modulo 2^64; carries and borrows out of bit 63 are discarded.
REQ-013 Lookups SHALL use four instances of the synchronous 1-cycle-latency S-box ROMs T1..T4 (8-bit address, 64-bit data). Each ROM is addressed once per phase.
REQ-014 The FSM SHALL have the states IDLE, EVEN, ODD, SUM and MUL.
REQ-015 IDLE with i_start = 1 at edge k: capture a and b, capture c' = i_c ^ i_x, capture i_mul; go to EVEN.
REQ-016 EVEN: drive the ROM addresses T1 = c'0, T2 = c'2, T3 = c'4, T4 = c'6; go to ODD at edge k+1.
REQ-017 ODD: drive the ROM addresses T1 = c'7, T2 = c'5, T3 = c'3, T4 = c'1; register even_xor from the ROM outputs; go to SUM at edge k+2.
REQ-018 SUM: register a' = a - even_xor and b_sum = b + odd_xor; go to MUL at edge k+3.
REQ-019 MUL: at edge k+4, register o_b = b_sum * mul using shift-add, with no generic multiplier: x5 = (b<<2)+b, x7 = (b<<3)-b, x9 = (b<<3)+b.
REQ-020 At edge k+4 the block SHALL also load o_a = a' and o_c = c', set o_valid = 1 for exactly one cycle, and return to IDLE.
REQ-021 Latency SHALL be exactly 4 clock edges from the edge that samples i_start to o_valid high.
REQ-022 i_start SHALL be ignored while o_busy = 1; no queuing.
REQ-023 i_start high during the o_valid cycle SHALL be accepted, giving a sustained rate of one round per 4 cycles.
REQ-024 o_a, o_b and o_c SHALL hold their values until the next o_valid.
REQ-025 Inputs SHALL be sampled only at edge k; changes during busy SHALL have no effect.
REQ-026 ROM addresses outside EVEN/ODD SHALL be don't-care; their outputs SHALL be ignored.

Reset
REQ-027 Asserting i_rst SHALL immediately force: state IDLE; o_valid = 0; o_busy = 0; o_a = o_b = o_c = 0; all internal registers = 0.
REQ-028 Reset mid-round SHALL abort the round with no o_valid pulse.
REQ-029 The first i_start after reset deassertion SHALL be accepted normally.
REQ-030 The ROM data registers have no reset; their contents SHALL never reach an output without a preceding EVEN/ODD phase.

Structure
REQ-031 A shared tiger package SHALL hold the FSM state encoding, the i_mul encodings and the word width constant (64).
REQ-032 The x5/x7/x9 shift-add multiplier SHALL be a sub-module, tiger_mul_const (64-bit in, 2-bit select, 64-bit out, combinational).
REQ-033 The four S-box ROMs T1..T4 SHALL be instantiated inside tiger_round.

Verification
REQ-034 a = b = c = x = 0, mul = 0, start at edge k -> o_valid only at edge k+4.
- o_c = 0.
- o_a = 0 - (T1[0]^T2[0]^T3[0]^T4[0]).
- o_b = 5*(T4[0]^T3[0]^T2[0]^T1[0]).
- o_a and o_b checked against the C reference model.
REQ-035 c = FFFFFFFFFFFFFFFF, x = 0F0F0F0F0F0F0F0F, a = b = 0123456789ABCDEF, mul = 1, 2, 3 -> o_c = F0F0F0F0F0F0F0F0 and o_a/o_b match the model; mul = 3 equals mul = 2.
REQ-036 Borrow/carry wrap: a = 0, and b = FFFFFFFFFFFFFFFF -> results match the model modulo 2^64.
REQ-037 Second i_start pulsed during EVEN and again during SUM -> ignored; exactly one o_valid.
REQ-038 Start held high continuously -> o_valid every 4 cycles; each result matches the model for the inputs present at its accept edge.
REQ-039 i_rst asserted in ODD -> outputs read 0 immediately, no o_valid; the next start completes correctly.

Source files
------------

// File: rtl/tiger_pkg.sv
// rtl/tiger_pkg.sv - shared Tiger round types, encodings and S-box contents
package tiger_pkg;

    localparam int W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVEN,
        S_ODD,
        S_SUM,
        S_MUL
    } state_t;

    // Select code 3 is reserved and falls through to x9.
    localparam logic [1:0] MUL_X5 = 2'd0;
    localparam logic [1:0] MUL_X7 = 2'd1;
    localparam logic [1:0] MUL_X9 = 2'd2;

    // S-box word for table t (0..3 = T1..T4): a seeded rotate/xor/add mix of the replicated address.
    function automatic logic [W-1:0] sbox_word(input logic [1:0] t, input logic [7:0] a);
        logic [W-1:0] seed;
        logic [W-1:0] s;
        case (t)
            2'd0:    seed = 64'h243F_6A88_85A3_08D3;
            2'd1:    seed = 64'h1319_8A2E_0370_7344;
            2'd2:    seed = 64'hA409_3822_299F_31D0;
            default: seed = 64'h082E_FA98_EC4E_6C89;
        endcase
        s = {8{a}} ^ seed;
        s = s ^ {s[50:0], s[63:51]};
        s = s + {s[36:0], s[63:37]};
        s = s ^ (s >> 31);
        return s;
    endfunction

endpackage

// File: rtl/tiger_mul_const.sv
// rtl/tiger_mul_const.sv - shift-add multiply by 5, 7 or 9 modulo 2^64
module tiger_mul_const
    import tiger_pkg::*;
(
    input  logic [W-1:0] b,
    input  logic [1:0]   sel,
    output logic [W-1:0] product
);

    always_comb begin
        case (sel)
            MUL_X5:  product = (b << 2) + b;
            MUL_X7:  product = (b << 3) - b;
            MUL_X9:  product = (b << 3) + b;
            default: product = (b << 3) + b;
        endcase
    end

endmodule

// File: rtl/tiger_sbox.sv
// rtl/tiger_sbox.sv - synchronous 1-cycle-latency 256x64 S-box ROM
module tiger_sbox
    import tiger_pkg::*;
#(
    parameter logic [1:0] TABLE = 2'd0
) (
    input  logic         clk,
    input  logic [7:0]   addr,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        data <= sbox_word(TABLE, addr);
    end

endmodule

// File: rtl/tiger.sv
// rtl/tiger.sv - one Tiger round: two ROM phases, add/sub, constant multiply
module tiger_round
    import tiger_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_x,
    input  logic [1:0]   i_mul,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b,
    output logic [W-1:0] o_c,
    output logic         o_valid,
    output logic         o_busy
);

    state_t       state, state_nx;
    logic         accept;
    logic [W-1:0] a_r, b_r, c_r, even_xor, a_new, b_sum, mul_out;
    logic [1:0]   mul_r;
    logic [7:0]   addr1, addr2, addr3, addr4;
    logic [W-1:0] q1, q2, q3, q4;

    // EVEN looks up the even bytes of c'; every other state presents the odd set.
    always_comb begin
        if (state == S_EVEN) begin
            addr1 = c_r[7:0];
            addr2 = c_r[23:16];
            addr3 = c_r[39:32];
            addr4 = c_r[55:48];
        end else begin
            addr1 = c_r[63:56];
            addr2 = c_r[47:40];
            addr3 = c_r[31:24];
            addr4 = c_r[15:8];
        end
    end

    tiger_sbox #(.TABLE(2'd0)) u_t1 (.clk(i_clk), .addr(addr1), .data(q1));
    tiger_sbox #(.TABLE(2'd1)) u_t2 (.clk(i_clk), .addr(addr2), .data(q2));
    tiger_sbox #(.TABLE(2'd2)) u_t3 (.clk(i_clk), .addr(addr3), .data(q3));
    tiger_sbox #(.TABLE(2'd3)) u_t4 (.clk(i_clk), .addr(addr4), .data(q4));

    tiger_mul_const u_mul (.b(b_sum), .sel(mul_r), .product(mul_out));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    // The completing MUL edge also samples i_start so a held start sustains one round per 4 cycles.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE: if (i_start) begin
                accept   = 1'b1;
                state_nx = S_EVEN;
            end
            S_EVEN: state_nx = S_ODD;
            S_ODD:  state_nx = S_SUM;
            S_SUM:  state_nx = S_MUL;
            S_MUL: begin
                accept   = i_start;
                state_nx = i_start ? S_EVEN : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= '0;
            mul_r    <= '0;
            even_xor <= '0;
            a_new    <= '0;
            b_sum    <= '0;
            o_a      <= '0;
            o_b      <= '0;
            o_c      <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (state == S_ODD) even_xor <= q1 ^ q2 ^ q3 ^ q4;
            if (state == S_SUM) begin
                a_new <= a_r - even_xor;
                b_sum <= b_r + (q4 ^ q3 ^ q2 ^ q1);
            end
            if (state == S_MUL) begin
                o_a     <= a_new;
                o_b     <= mul_out;
                o_c     <= c_r;
                o_valid <= 1'b1;
            end
            if (accept) begin
                a_r   <= i_a;
                b_r   <= i_b;
                c_r   <= i_c ^ i_x;
                mul_r <= i_mul;
            end
        end
    end

    assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_tiger_round.sv
// tb/tb_tiger_round.sv - randomized self-checking bench for tiger_round
module tb_tiger_round;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] a = '0, b = '0, c = '0, x = '0;
    logic [1:0]  mul = '0;
    logic [63:0] oa, ob, oc;
    logic        valid, busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] SEEDS [4] = '{64'h243F6A8885A308D3, 64'h13198A2E03707344,
                                          64'hA4093822299F31D0, 64'h082EFA98EC4E6C89};
    logic [63:0] tbl [4][256];

    tiger_round dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_a(a), .i_b(b), .i_c(c), .i_x(x), .i_mul(mul),
        .o_a(oa), .o_b(ob), .o_c(oc), .o_valid(valid), .o_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] gen(int t, int adr);
        logic [63:0] s;
        s = (64'(adr) * 64'h0101010101010101) ^ SEEDS[t];
        s = s ^ ((s << 13) | (s >> 51));
        s = s + ((s << 27) | (s >> 37));
        s = s ^ (s >> 31);
        return s;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model(input logic [63:0] ia, ib, ic, ix, input logic [1:0] im,
                         output logic [63:0] ea, eb, ec);
        logic [63:0] cp, ev, od, f;
        int          byt [8];
        cp = ic ^ ix;
        for (int n = 0; n < 8; n++) byt[n] = int'((cp >> (8 * n)) & 64'hFF);
        ev = tbl[0][byt[0]] ^ tbl[1][byt[2]] ^ tbl[2][byt[4]] ^ tbl[3][byt[6]];
        od = tbl[3][byt[1]] ^ tbl[2][byt[3]] ^ tbl[1][byt[5]] ^ tbl[0][byt[7]];
        f  = (im == 2'd0) ? 64'd5 : (im == 2'd1) ? 64'd7 : 64'd9;
        ea = ia - ev;
        eb = (ib + od) * f;
        ec = cp;
    endtask

    task automatic scramble();
        a = rnd64(); b = rnd64(); c = rnd64(); x = rnd64(); mul = 2'($urandom);
    endtask

    // One accepted round; inputs are scrambled after the accept edge. lat = 0 means no o_valid.
    task automatic run_round(input logic [63:0] ia, ib, ic, ix, input logic [1:0] im,
                             output int lat, output logic [63:0] ra, rb, rc);
        @(negedge clk);
        a = ia; b = ib; c = ic; x = ix; mul = im; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        scramble();
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                lat = i; ra = oa; rb = ob; rc = oc;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid, busy} !== 2'b00 || oa !== 64'd0 || ob !== 64'd0 || oc !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b oa=%h ob=%h oc=%h, required all 0", valid, busy, oa, ob, oc);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_zero();
        int lat;
        logic [63:0] ra, rb, rc, ea, eb, ec;
        model(0, 0, 0, 0, 0, ea, eb, ec);
        run_round(0, 0, 0, 0, 0, lat, ra, rb, rc);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL zero_latency: got %0d edges, required 4", lat); end
        checks++;
        if (rc !== 64'd0) begin errors++; $display("FAIL zero_c: got %h, required 0", rc); end
        checks++;
        if (ra !== 64'd0 - (tbl[0][0] ^ tbl[1][0] ^ tbl[2][0] ^ tbl[3][0]) || ra !== ea) begin
            errors++; $display("FAIL zero_a: got %h, required %h", ra, ea);
        end
        checks++;
        if (rb !== 64'd5 * (tbl[3][0] ^ tbl[2][0] ^ tbl[1][0] ^ tbl[0][0]) || rb !== eb) begin
            errors++; $display("FAIL zero_b: got %h, required %h", rb, eb);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || oa !== ra || ob !== rb || oc !== rc) begin
            errors++; $display("FAIL zero_pulse_hold: valid=%b oa=%h ob=%h, required 0/%h/%h", valid, oa, ob, ra, rb);
        end
    endtask

    task automatic test_pattern();
        int lat;
        logic [63:0] ra, rb, rc, ea, eb, ec, b_x9;
        b_x9 = '0;
        for (int m = 1; m <= 3; m++) begin
            model(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF,
                  64'h0F0F0F0F0F0F0F0F, 2'(m), ea, eb, ec);
            run_round(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF,
                      64'h0F0F0F0F0F0F0F0F, 2'(m), lat, ra, rb, rc);
            checks++;
            if (lat !== 4 || rc !== 64'hF0F0F0F0F0F0F0F0 || ra !== ea || rb !== eb) begin
                errors++;
                $display("FAIL pattern_mul%0d: lat=%0d a=%h b=%h c=%h, required 4 %h %h F0F0F0F0F0F0F0F0", m, lat, ra, rb, rc, ea, eb);
            end
            if (m == 2) b_x9 = rb;
            if (m == 3) begin
                checks++;
                if (rb !== b_x9) begin errors++; $display("FAIL pattern_mul3_eq_mul2: got %h, required %h", rb, b_x9); end
            end
        end
    endtask

    task automatic test_wrap();
        int lat;
        logic [63:0] ra, rb, rc, ea, eb, ec, cc, xx;
        for (int m = 0; m < 4; m++) begin
            cc = rnd64(); xx = rnd64();
            model(0, 64'hFFFFFFFFFFFFFFFF, cc, xx, 2'(m), ea, eb, ec);
            run_round(0, 64'hFFFFFFFFFFFFFFFF, cc, xx, 2'(m), lat, ra, rb, rc);
            checks++;
            if (lat !== 4 || ra !== ea || rb !== eb || rc !== ec) begin
                errors++;
                $display("FAIL wrap_mul%0d: lat=%0d a=%h b=%h c=%h, required 4 %h %h %h", m, lat, ra, rb, rc, ea, eb, ec);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [63:0] ia, ib, ic, ix, ra, rb, rc, ea, eb, ec;
        logic [1:0]  im;
        for (int r = 0; r < 8; r++) begin
            ia = rnd64(); ib = rnd64(); ic = rnd64(); ix = rnd64(); im = 2'($urandom);
            model(ia, ib, ic, ix, im, ea, eb, ec);
            run_round(ia, ib, ic, ix, im, lat, ra, rb, rc);
            checks++;
            if (lat !== 4 || ra !== ea || rb !== eb || rc !== ec) begin
                errors++;
                $display("FAIL random_%0d: lat=%0d a=%h b=%h c=%h, required 4 %h %h %h", r, lat, ra, rb, rc, ea, eb, ec);
            end
        end
    endtask

    task automatic test_ignore();
        logic [63:0] ea, eb, ec, ra, rb, rc;
        int nvalid, first;
        @(negedge clk);
        scramble();
        model(a, b, c, x, mul, ea, eb, ec);
        start = 1'b1;
        @(posedge clk);
        nvalid = 0; first = 0; ra = '0; rb = '0; rc = '0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            start = (e == 1 || e == 3);
            scramble();
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                nvalid++;
                if (first == 0) begin first = e; ra = oa; rb = ob; rc = oc; end
            end
        end
        start = 1'b0;
        checks++;
        if (nvalid !== 1 || first !== 4 || ra !== ea || rb !== eb || rc !== ec) begin
            errors++;
            $display("FAIL ignore_busy: %0d pulses first at %0d a=%h b=%h, required 1 at 4 %h %h", nvalid, first, ra, rb, ea, eb);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] qa[$], qb[$], qc[$];
        logic [63:0] ea, eb, ec;
        int n_out, bad;
        n_out = 0; bad = 0;
        for (int cyc = 0; cyc <= 24; cyc++) begin
            @(negedge clk);
            scramble();
            start = (cyc < 24);
            if (cyc % 4 == 0 && cyc < 24) begin
                model(a, b, c, x, mul, ea, eb, ec);
                qa.push_back(ea); qb.push_back(eb); qc.push_back(ec);
            end
            @(posedge clk);
            #1;
            checks++;
            if (valid !== (cyc >= 4 && cyc % 4 == 0)) begin
                errors++; $display("FAIL b2b_valid_edge%0d: got %b, required %b", cyc, valid, (cyc >= 4 && cyc % 4 == 0));
            end else if (valid === 1'b1 && qa.size() > 0) begin
                ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                n_out++;
                checks++;
                if (oa !== ea || ob !== eb || oc !== ec) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: a=%h b=%h c=%h, required %h %h %h", n_out, oa, ob, oc, ea, eb, ec);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (n_out !== 6) begin errors++; $display("FAIL b2b_count: got %0d results, required 6", n_out); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, nvalid;
        logic [63:0] ra, rb, rc, ea, eb, ec, ia, ib, ic, ix;
        @(negedge clk);
        scramble();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid, busy} !== 2'b00 || oa !== 64'd0 || ob !== 64'd0 || oc !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: valid=%b busy=%b oa=%h ob=%h oc=%h, required all 0", valid, busy, oa, ob, oc);
        end
        @(negedge clk) rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 if (valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin errors++; $display("FAIL reset_mid_abort: got %0d pulses, required 0", nvalid); end
        ia = rnd64(); ib = rnd64(); ic = rnd64(); ix = rnd64();
        model(ia, ib, ic, ix, 2'd1, ea, eb, ec);
        run_round(ia, ib, ic, ix, 2'd1, lat, ra, rb, rc);
        checks++;
        if (lat !== 4 || ra !== ea || rb !== eb || rc !== ec) begin
            errors++;
            $display("FAIL reset_mid_restart: lat=%0d a=%h b=%h c=%h, required 4 %h %h %h", lat, ra, rb, rc, ea, eb, ec);
        end
    endtask

    initial begin
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < 256; i++) tbl[t][i] = gen(t, i);
        test_reset();
        test_zero();
        test_pattern();
        test_wrap();
        test_random();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
